// File: rtl/interrupt_controller.sv
// Machine-mode interrupt controller.
// Holds mstatus (MIE/MPIE), mie, mip, mtvec, mepc and mcause, exposes them on a
// read/write/address bus with a shared tri-state data line, and runs the
// request/acknowledge handshake that hands a trap target PC to the core.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   read, write         CSR strobes; data is driven only when read=1, write=0
//   address[2:0]        0 mstatus, 1 mie, 2 mip, 3 mtvec, 4 mepc, 5 mcause
//   data[31:0]          bidirectional CSR data
//   timer_interrupt     level from the real-time clock
//   external_interrupt  level external interrupt
//   irq_ack             core takes the trap this cycle
//   pc_in[31:0]         PC saved into mepc on irq_ack
//   mret                core executes MRET this cycle
//   irq_request         trap pending toward the core
//   trap_vector[31:0]   handler address, valid while irq_request=1
module interrupt_controller #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [2:0]  address,
  inout  logic [31:0] data,
  input  logic        timer_interrupt,
  input  logic        external_interrupt,
  input  logic        irq_ack,
  input  logic [31:0] pc_in,
  input  logic        mret,
  output logic        irq_request,
  output logic [31:0] trap_vector
);

  localparam logic [31:0] MIE_MASK  = 32'h0000_0888;
  localparam logic [31:0] EPC_MASK  = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, REQUEST, HANDLER} state_t;

  state_t      state, state_next;
  logic        status_mie, status_mpie;
  logic [31:0] mie_reg;
  logic        msip;
  logic [31:0] mtvec, mepc, mcause;

  logic [31:0] mstatus_val, mip_val, pending, rdata;
  logic [3:0]  code;
  logic [31:0] cause, target;
  logic        ack_take;
  logic        wr_mstatus, wr_mie, wr_mip, wr_mtvec, wr_mepc, wr_mcause;

  assign mstatus_val = {24'b0, status_mpie, 3'b0, status_mie, 3'b0};
  // MTIP/MEIP are live views of the input levels, not stored bits.
  assign mip_val     = {20'b0, external_interrupt, 3'b0, timer_interrupt, 3'b0, msip, 3'b0};
  assign pending     = mip_val & mie_reg & {32{status_mie}};

  // Fixed priority MEI > MSI > MTI; code 0 only when nothing is pending.
  always_comb begin
    code = 4'd0;
    if (pending[11])     code = 4'd11;
    else if (pending[3]) code = 4'd3;
    else if (pending[7]) code = 4'd7;
  end

  assign cause = {1'b1, 27'b0, code};

  always_comb begin
    target = {mtvec[31:2], 2'b00};
    if (mtvec[1:0] == 2'b01) target = target + {26'b0, code, 2'b00};
  end

  assign irq_request = (state == REQUEST);
  assign trap_vector = (state == REQUEST) ? target : '0;

  // An ack only counts while a source is still pending in REQUEST.
  assign ack_take = (state == REQUEST) && (pending != '0) && irq_ack;

  assign wr_mstatus = write && (address == 3'd0);
  assign wr_mie     = write && (address == 3'd1);
  assign wr_mip     = write && (address == 3'd2);
  assign wr_mtvec   = write && (address == 3'd3);
  assign wr_mepc    = write && (address == 3'd4);
  assign wr_mcause  = write && (address == 3'd5);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pending != '0) state_next = REQUEST;
      REQUEST: begin
        if (pending == '0) state_next = IDLE;
        else if (irq_ack)  state_next = HANDLER;
      end
      HANDLER: if (mret) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      status_mie  <= 1'b0;
      status_mpie <= 1'b0;
      mie_reg     <= '0;
      msip        <= 1'b0;
      mtvec       <= MTVEC_RESET;
      mepc        <= '0;
      mcause      <= '0;
    end else begin
      if (wr_mie)   mie_reg <= data & MIE_MASK;
      if (wr_mip)   msip    <= data[3];
      if (wr_mtvec) mtvec   <= data;

      if (ack_take) begin
        mepc   <= pc_in & EPC_MASK;
        mcause <= cause;
      end else begin
        if (wr_mepc)   mepc   <= data & EPC_MASK;
        if (wr_mcause) mcause <= data;
      end

      // Trap entry beats MRET, and both beat a software mstatus write.
      if (ack_take) begin
        status_mpie <= status_mie;
        status_mie  <= 1'b0;
      end else if (mret) begin
        status_mie  <= status_mpie;
        status_mpie <= 1'b1;
      end else if (wr_mstatus) begin
        status_mie  <= data[3];
        status_mpie <= data[7];
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (address)
      3'd0:    rdata = mstatus_val;
      3'd1:    rdata = mie_reg;
      3'd2:    rdata = mip_val;
      3'd3:    rdata = mtvec;
      3'd4:    rdata = mepc;
      3'd5:    rdata = mcause;
      default: rdata = '0;
    endcase
  end

  assign data = (read && !write) ? rdata : 'z;

endmodule
